// File: rtl/fp_vector_assembler.sv
// Collects scalar IEEE-754 single-precision words into LENGTH-element packed vectors.
// Element i lands at out_data[i*32 +: 32]; short vectors closed by in_last are zero-padded.
module fp_vector_assembler #(
    parameter int LENGTH = 3,
    parameter int WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH*LENGTH-1:0]      out_data,
    output logic [$clog2(LENGTH+1)-1:0]  out_count,
    output logic                         out_short
);
    localparam int CW = $clog2(LENGTH+1);
    localparam int IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    typedef enum logic {FILL, PEND} state_t;

    state_t                         state;
    logic [IW-1:0]                  idx;
    logic [LENGTH-1:0][WIDTH-1:0]   vbuf, merged, out_q;
    logic [CW-1:0]                  pend_count, count_next;
    logic                           pend_short, short_next;
    logic                           fire_in, out_free, complete;

    assign in_ready   = (state == FILL);
    assign fire_in    = in_valid && in_ready;
    assign out_free   = !out_valid || out_ready;
    assign complete   = fire_in && (in_last || idx == IW'(LENGTH-1));
    assign count_next = CW'(idx) + CW'(1);
    assign short_next = count_next < CW'(LENGTH);
    assign out_data   = out_q;

    // Unfilled slots above idx are already zero because vbuf is cleared per vector.
    for (genvar i = 0; i < LENGTH; i++) begin : g_slot
        assign merged[i] = (fire_in && idx == IW'(i)) ? in_data : vbuf[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            idx        <= '0;
            vbuf       <= '0;
            out_q      <= '0;
            out_valid  <= 1'b0;
            out_count  <= '0;
            out_short  <= 1'b0;
            pend_count <= '0;
            pend_short <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                FILL: begin
                    if (fire_in) begin
                        if (complete) begin
                            idx <= '0;
                            if (out_free) begin
                                out_q     <= merged;
                                out_count <= count_next;
                                out_short <= short_next;
                                out_valid <= 1'b1;
                                vbuf      <= '0;
                            end else begin
                                // Output still held: park the finished vector until it drains.
                                vbuf       <= merged;
                                pend_count <= count_next;
                                pend_short <= short_next;
                                state      <= PEND;
                            end
                        end else begin
                            vbuf <= merged;
                            idx  <= idx + IW'(1);
                        end
                    end
                end
                PEND: begin
                    if (out_free) begin
                        out_q     <= vbuf;
                        out_count <= pend_count;
                        out_short <= pend_short;
                        out_valid <= 1'b1;
                        vbuf      <= '0;
                        idx       <= '0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_vector_assembler.sv
// Directed bench with scoreboard for fp_vector_assembler (LENGTH=3 and LENGTH=1 instances).
module tb_fp_vector_assembler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_last, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_short;
    logic [95:0] out_data;
    logic [1:0]  out_count;

    logic        in_valid1, in_last1, out_ready1;
    logic [31:0] in_data1;
    logic        in_ready1, out_valid1, out_short1;
    logic [31:0] out_data1;
    logic [0:0]  out_count1;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    typedef struct packed {
        logic [95:0] data;
        logic [1:0]  count;
        logic        shrt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] part[$];

    fp_vector_assembler #(.LENGTH(3), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_short(out_short)
    );

    fp_vector_assembler #(.LENGTH(1), .WIDTH(32)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_last(in_last1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_count(out_count1), .out_short(out_short1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model: gather accepted elements, emit an expected vector on close.
    task automatic model_push(input logic [31:0] d, input logic l);
        exp_t e;
        part.push_back(d);
        if (l || part.size() == 3) begin
            e.data = '0;
            for (int i = 0; i < part.size(); i++) e.data[i*32 +: 32] = part[i];
            e.count = 2'(part.size());
            e.shrt  = (part.size() < 3);
            exp_q.push_back(e);
            part.delete();
        end
    endtask

    task automatic model_reset();
        part.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [31:0] d, input logic l, output int stall);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        stall    = 0;
        @(negedge clk);
        while (!in_ready && stall < 50) begin
            stall++;
            @(negedge clk);
        end
        check("send_ready", 96'(in_ready), 96'(1'b1));
        if (in_ready) model_push(d, l);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_vector", out_data, 96'h0);
            end else begin
                e = exp_q.pop_front();
                check("sb_data",  out_data,        e.data);
                check("sb_count", 96'(out_count), 96'(e.count));
                check("sb_short", 96'(out_short), 96'(e.shrt));
            end
        end
    end

    initial begin
        int st, stall_sum, n0;
        rst_n = 1'b1; in_valid = 0; in_last = 0; in_data = '0; out_ready = 1'b1;
        in_valid1 = 0; in_last1 = 0; in_data1 = '0; out_ready1 = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 96'(out_valid), 96'(0));
        check("rst_out_data",  out_data,       96'h0);
        check("rst_out_count", 96'(out_count), 96'(0));
        check("rst_out_short", 96'(out_short), 96'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        check("rst_in_ready", 96'(in_ready), 96'(1));

        // Full vector, one-cycle latency
        send(32'h3F800000, 0, st);
        send(32'h40000000, 0, st);
        send(32'h40400000, 0, st);
        check("full_latency_valid", 96'(out_valid), 96'(1));
        check("full_data", out_data, 96'h40400000_40000000_3F800000);

        // Short vector, then next vector starts at slot 0
        send(32'hBFC00000, 1, st);
        check("short_data",  out_data,       96'h00000000_00000000_BFC00000);
        check("short_count", 96'(out_count), 96'(1));
        check("short_flag",  96'(out_short), 96'(1));
        // in_last without in_valid must be ignored
        in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1 in_last = 1'b0;
        send(32'h00000011, 0, st);
        send(32'h00000022, 1, st);
        send(32'h00000033, 0, st);
        send(32'h00000044, 0, st);
        send(32'h00000055, 1, st);   // in_last on last slot: full, not short
        check("last_on_full_short", 96'(out_short), 96'(0));

        // Backpressure: first vector held, second parks in PEND
        @(posedge clk); #1 out_ready = 1'b0;
        send(32'h11111111, 0, st);
        send(32'h22222222, 0, st);
        send(32'h33333333, 0, st);
        send(32'h44444444, 0, st);
        send(32'h55555555, 0, st);
        send(32'h66666666, 0, st);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_data",  out_data,       96'h33333333_22222222_11111111);
            check("bp_in_ready",   96'(in_ready),  96'(0));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_low_before_load", 96'(in_ready), 96'(0));
        @(posedge clk); #1;
        check("bp_ready_back", 96'(in_ready), 96'(1));
        check("bp_second_data", out_data, 96'h66666666_55555555_44444444);
        repeat (3) @(posedge clk);
        #1;

        // Streaming: 30 elements, no stalls, 10 vectors
        n0 = n_out; stall_sum = 0;
        for (int k = 0; k < 30; k++) begin
            send(32'hC0000000 + 32'(k), 0, st);
            stall_sum += st;
        end
        repeat (3) @(posedge clk);
        #1;
        check("stream_stalls",  96'(stall_sum),    96'(0));
        check("stream_vectors", 96'(n_out - n0),   96'(10));

        // Async reset mid-vector
        send(32'hDEAD0001, 0, st);
        send(32'hDEAD0002, 0, st);
        #2 rst_n = 1'b0;
        #1 check("rstmid_out_valid", 96'(out_valid), 96'(0));
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        send(32'h0000A001, 0, st);
        send(32'h0000A002, 0, st);
        send(32'h0000A003, 0, st);
        check("rstmid_post_data", out_data, 96'h0000A003_0000A002_0000A001);

        // Async reset while in PEND with a held output
        @(posedge clk); #1 out_ready = 1'b0;
        for (int k = 0; k < 6; k++) send(32'hB0000000 + 32'(k), 0, st);
        check("pend_in_ready", 96'(in_ready), 96'(0));
        #2 rst_n = 1'b0;
        #1;
        check("rstpend_out_valid", 96'(out_valid), 96'(0));
        check("rstpend_out_data",  out_data,       96'h0);
        check("rstpend_in_ready",  96'(in_ready),  96'(1));
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
        send(32'h0000E001, 1, st);
        send(32'h0000E002, 0, st);
        send(32'h0000E003, 0, st);
        send(32'h0000E004, 0, st);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        #1 check("sb_drained", 96'(exp_q.size()), 96'(0));

        // LENGTH=1: each element is its own vector, bit-exact
        in_valid1 = 1'b1; in_data1 = 32'h7FC00001;
        @(negedge clk) check("l1_ready", 96'(in_ready1), 96'(1));
        @(posedge clk); #1 in_valid1 = 1'b1; in_data1 = 32'h00000001; in_last1 = 1'b1;
        check("l1_nan_valid", 96'(out_valid1), 96'(1));
        check("l1_nan_data",  96'(out_data1),  96'(32'h7FC00001));
        check("l1_nan_count", 96'(out_count1), 96'(1));
        check("l1_nan_short", 96'(out_short1), 96'(0));
        @(posedge clk); #1 in_valid1 = 1'b0; in_last1 = 1'b0;
        check("l1_den_data",  96'(out_data1),  96'(32'h00000001));
        check("l1_den_count", 96'(out_count1), 96'(1));
        check("l1_den_short", 96'(out_short1), 96'(0));
        @(posedge clk); #1;
        check("l1_idle_valid", 96'(out_valid1), 96'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_vector_assembler.md
Name: fp_vector_assembler

Overview:
- Inverse of the packed-vector consumer used by the FP sim/debug path: takes a stream of scalar IEEE-754 single-precision words and assembles them into LENGTH-element packed vectors.
- Output packing is element i at bits [i*32 +: 32], the same packing every vector consumer in the design expects.
- Sits between scalar producers (testbench file readers, the scalar divider/sqrt units) and vector datapaths.
- Valid/ready on both sides; supports short vectors terminated by in_last, zero-padded.

Parameters:
- LENGTH, 3, number of 32-bit elements per vector (>=1).
- WIDTH, 32, element width; fixed at 32, and other values are unsupported.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  scalar element valid.
- in_ready  output  1  block accepts element this cycle.
- in_data  input  32  IEEE-754 single-precision element.
- in_last  input  1  element closes the current vector.
- out_valid  output  1  assembled vector valid.
- out_ready  input  1  downstream accepts vector.
- out_data  output  WIDTH*LENGTH  packed vector, element i at [i*32 +: 32].
- out_count  output  $clog2(LENGTH+1)  number of real (non-padded) elements, 1..LENGTH.
- out_short  output  1  vector closed by in_last before LENGTH elements.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_count=0, out_short=0.
  - Element index idx=0, assembly buffer=0, state=FILL.
  - in_ready takes its FILL value (1) after reset deasserts.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_data, out_count and out_short hold stable while out_valid && !out_ready.
- Output register "free" means !out_valid || out_ready in the same cycle.
- State FILL:
  - in_ready=1.
  - On input transfer, the element is written to buffer slot idx.
  - Completing transfer: idx==LENGTH-1 or in_last=1.
  - Non-completing transfer: idx increments.
- Completing transfer in FILL with output register free:
  - On the same edge, the output register loads buffer merged with the new element; slots above idx load +0.0 (32'h0).
  - out_count=idx+1; out_short=(idx+1<LENGTH).
  - out_valid=1 next cycle, so latency is 1 cycle from the last element's handshake.
  - idx=0, buffer cleared, state stays FILL. Sustained throughput is one element per cycle.
- Completing transfer in FILL with output register not free:
  - The element is stored in the buffer and the count/short result is latched.
  - Next state is PEND.
- State PEND:
  - in_ready=0.
  - Each cycle the output register is free, the output register loads the buffer (padding already zero), out_valid=1, buffer cleared, idx=0, state=FILL.
  - in_ready returns to 1 in the cycle after that load.
- in_last on element LENGTH-1 is a normal full vector: out_short=0.
- in_last is ignored when in_valid=0.
- Simultaneous output drain and completing transfer load directly; no bubble.
- Element bits pass through unmodified (NaN/denormal payloads preserved); no FP arithmetic.
- LENGTH=1: every accepted element is a complete vector; out_short is always 0.
- Reset mid-vector or in PEND discards the partial vector and any held output.

Test Plan:
- Full vector, LENGTH=3, out_ready=1:
  - Stimulus: send 3F800000, 40000000, 40400000 back-to-back.
  - Response: out_valid one cycle after the 3rd handshake, out_data=40400000_40000000_3F800000, out_count=3, out_short=0.
- Short vector:
  - Stimulus: send BFC00000 with in_last=1.
  - Response: out_data=00000000_00000000_BFC00000, out_count=1, out_short=1.
  - Follow-up: the next vector starts at slot 0.
- Backpressure:
  - Stimulus: out_ready=0, send 6 elements.
  - Response: first vector held stable; second vector completes into PEND, then in_ready=0.
  - Release: raise out_ready; the two vectors emerge in order with no loss; in_ready returns to 1 the cycle after the second load.
- Streaming:
  - Stimulus: out_ready=1, 30 consecutive elements with in_valid=1.
  - Response: 10 vectors, in_ready never drops, one out_valid pulse every 3 cycles.
- Async reset:
  - Stimulus: assert rst_n=0 after 2 elements of a vector and while in PEND.
  - Response: out_valid=0 immediately without a clock edge; the next vector after reset contains only post-reset data.
- Special values:
  - Stimulus: LENGTH=1 with 7FC00001 (NaN) and 00000001 (denormal).
  - Response: each output vector equals its input bit-exactly, out_count=1.
